instr_sequencer: RTL

//  Instruction issuer for the 8-bit bus CPU: drives the CPU's Run/Rx/Ry/Fun/Data

---
 rtl/instr_sequencer_if.sv | 29 ++
 rtl/instr_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : instr_sequencer_if                                            |
// | Description : Host write port and CPU Run/Rx/Ry/Fun/Data/Done handshake.    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
interface instr_sequencer_if;
  logic        wr_valid;
  logic [13:0] wr_instr;
  logic        wr_ready;
  logic        Run;
  logic [1:0]  Rx;
  logic [1:0]  Ry;
  logic [1:0]  Fun;
  logic [7:0]  Data;
  logic        Done;

  // master: the host writing words plus the CPU answering with Done
  modport master (
    output wr_valid, wr_instr, Done,
    input  wr_ready, Run, Rx, Ry, Fun, Data
  );

  modport slave (
    input  wr_valid, wr_instr, Done,
    output wr_ready, Run, Rx, Ry, Fun, Data
  );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : instr_sequencer                                               |
// | Description : FIFO-buffered instruction issuer for the 8-bit bus CPU, with  |
// |               Done handshake, completion counter and sticky timeout flag.   |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module instr_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic                   enable,
  input  wire logic                   clear_err,
  instr_sequencer_if.slave            bus,
  output logic                        busy,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic [7:0]                  done_count,
  output logic                        timeout_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t             state_q,    state_d;
  logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]   count_q,    count_d;
  logic [13:0]        mem_q [DEPTH];
  logic [13:0]        mem_d [DEPTH];
  logic [13:0]        instr_q,    instr_d;
  logic [TMR_W-1:0]   timer_q,    timer_d;
  logic [7:0]         done_cnt_q, done_cnt_d;
  logic               err_q,      err_d;

  logic               ready;
  logic               push;
  logic               pop;
  logic               timeout_hit;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  always_comb begin
    ready = (count_q < CNT_W'(DEPTH));
    push  = bus.wr_valid && ready;
    // Done still high in IDLE belongs to the previous instruction; wait it out.
    pop   = (state_q == S_IDLE) && enable && (count_q != '0) && !bus.Done;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.wr_instr;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    instr_d     = instr_q;
    done_cnt_d  = done_cnt_q;
    err_d       = err_q;
    timeout_hit = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          instr_d = mem_q[rd_ptr_q];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.Done) begin
          done_cnt_d = done_cnt_q + 8'd1;
          state_d    = S_RELEASE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          // Incremented timer reaching TIMEOUT-1 aborts the instruction.
          if (timer_q == TMR_W'(TIMEOUT - 2)) begin
            timeout_hit = 1'b1;
            state_d     = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        if (!bus.Done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear_err) begin
      err_d = 1'b0;
    end
    if (timeout_hit) begin
      err_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      instr_q    <= '0;
      timer_q    <= '0;
      done_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      timer_q    <= timer_d;
      done_cnt_q <= done_cnt_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.wr_ready = ready;
  assign bus.Run      = (state_q == S_ISSUE);
  assign bus.Fun      = instr_q[13:12];
  assign bus.Rx       = instr_q[11:10];
  assign bus.Ry       = instr_q[9:8];
  assign bus.Data     = instr_q[7:0];
  assign busy         = (state_q != S_IDLE);
  assign fifo_count   = count_q;
  assign done_count   = done_cnt_q;
  assign timeout_err  = err_q;

endmodule
`default_nettype wire
